// File: rtl/rs_pkg.sv
// Shared decode constants and the reservation-station entry layout.
package rs_pkg;

  localparam int RS_XLEN  = 32;
  localparam int RS_TAG_W = 5;

  localparam logic [RS_TAG_W-1:0] NO_TAG = '0;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADDSUB = 3'b000;
  localparam logic [2:0] OP_BEQ     = 3'b000;
  localparam logic [2:0] OP_BNE     = 3'b001;
  localparam logic [2:0] OP_BLT     = 3'b100;
  localparam logic [2:0] OP_BGE     = 3'b101;
  localparam logic [2:0] OP_BLTU    = 3'b110;
  localparam logic [2:0] OP_BGEU    = 3'b111;

  // Field widths follow RS_XLEN/RS_TAG_W; the station's XLEN/TAG_W default to these.
  typedef struct packed {
    logic                valid;
    logic [6:0]          opcode;
    logic [2:0]          fun3;
    logic [6:0]          fun7;
    logic [RS_TAG_W-1:0] dtag;
    logic [RS_XLEN-1:0]  vj;
    logic [RS_TAG_W-1:0] qj;
    logic [RS_XLEN-1:0]  vk;
    logic [RS_TAG_W-1:0] qk;
    logic [RS_XLEN-1:0]  imm;
  } rs_entry_t;

endpackage

// File: rtl/rs_select.sv
// Lowest-index priority picker over a request vector.
module rs_select #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 found_o
);
  localparam int IW = $clog2(N);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = IW'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_station.sv
// Tomasulo reservation station: collapsing age-ordered queue with CDB wakeup,
// oldest-ready (or oldest-only) dispatch, flush and valid/ready handshakes.
module rs_station
  import rs_pkg::*;
#(
  parameter int RS_DEPTH = 4,
  parameter int XLEN     = RS_XLEN,
  parameter int TAG_W    = RS_TAG_W,
  parameter bit IN_ORDER = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          issue_valid,
  output logic                          issue_ready,
  input  logic [6:0]                    issue_opcode,
  input  logic [2:0]                    issue_fun3,
  input  logic [6:0]                    issue_fun7,
  input  logic [TAG_W-1:0]              issue_dtag,
  input  logic [XLEN-1:0]               issue_vj,
  input  logic [TAG_W-1:0]              issue_qj,
  input  logic [XLEN-1:0]               issue_vk,
  input  logic [TAG_W-1:0]              issue_qk,
  input  logic [XLEN-1:0]               issue_imm,
  input  logic                          cdb_valid,
  input  logic [TAG_W-1:0]              cdb_tag,
  input  logic [XLEN-1:0]               cdb_data,
  output logic                          disp_valid,
  input  logic                          disp_ready,
  output logic [6:0]                    disp_opcode,
  output logic [2:0]                    disp_fun3,
  output logic [6:0]                    disp_fun7,
  output logic [TAG_W-1:0]              disp_dtag,
  output logic [XLEN-1:0]               disp_vj,
  output logic [XLEN-1:0]               disp_vk,
  output logic [XLEN-1:0]               disp_imm,
  output logic [$clog2(RS_DEPTH+1)-1:0] count,
  output logic                          full,
  output logic                          empty
);
  localparam int CW = $clog2(RS_DEPTH + 1);
  localparam int IW = $clog2(RS_DEPTH);

  rs_entry_t           ent_q [RS_DEPTH];
  rs_entry_t           ent_d [RS_DEPTH];
  rs_entry_t           woken [RS_DEPTH];
  rs_entry_t           new_ent;
  logic [CW-1:0]       count_q, count_d, wr_idx;
  logic [RS_DEPTH-1:0] rdy, pick;
  logic [IW-1:0]       sel_idx;
  logic                sel_found, do_disp, do_issue;

  for (genvar gi = 0; gi < RS_DEPTH; gi++) begin : g_rdy
    assign rdy[gi] = ent_q[gi].valid && (ent_q[gi].qj == NO_TAG) && (ent_q[gi].qk == NO_TAG);
  end

  // In-order stations only ever consider the head slot.
  assign pick = IN_ORDER ? (rdy & RS_DEPTH'(1)) : rdy;

  rs_select #(.N(RS_DEPTH)) u_sel (
    .req_i   (pick),
    .idx_o   (sel_idx),
    .found_o (sel_found)
  );

  assign full        = (count_q == CW'(RS_DEPTH));
  assign empty       = (count_q == '0);
  assign count       = count_q;
  assign issue_ready = !full && !flush && !rst;
  assign disp_valid  = sel_found;
  assign disp_opcode = ent_q[sel_idx].opcode;
  assign disp_fun3   = ent_q[sel_idx].fun3;
  assign disp_fun7   = ent_q[sel_idx].fun7;
  assign disp_dtag   = ent_q[sel_idx].dtag;
  assign disp_vj     = ent_q[sel_idx].vj;
  assign disp_vk     = ent_q[sel_idx].vk;
  assign disp_imm    = ent_q[sel_idx].imm;

  assign do_disp  = sel_found && disp_ready;
  assign do_issue = issue_valid && issue_ready;
  assign wr_idx   = count_q - CW'(do_disp);
  assign count_d  = count_q + CW'(do_issue) - CW'(do_disp);

  always_comb begin
    new_ent        = '0;
    new_ent.valid  = 1'b1;
    new_ent.opcode = issue_opcode;
    new_ent.fun3   = issue_fun3;
    new_ent.fun7   = issue_fun7;
    new_ent.dtag   = issue_dtag;
    new_ent.vj     = issue_vj;
    new_ent.qj     = issue_qj;
    new_ent.vk     = issue_vk;
    new_ent.qk     = issue_qk;
    new_ent.imm    = issue_imm;
    // Issue-cycle bypass: a producer broadcasting now must not be missed.
    if (cdb_valid && issue_qj != NO_TAG && issue_qj == cdb_tag) begin
      new_ent.vj = cdb_data;
      new_ent.qj = NO_TAG;
    end
    if (cdb_valid && issue_qk != NO_TAG && issue_qk == cdb_tag) begin
      new_ent.vk = cdb_data;
      new_ent.qk = NO_TAG;
    end

    for (int i = 0; i < RS_DEPTH; i++) begin
      woken[i] = ent_q[i];
      if (cdb_valid && ent_q[i].valid && ent_q[i].qj != NO_TAG && ent_q[i].qj == cdb_tag) begin
        woken[i].vj = cdb_data;
        woken[i].qj = NO_TAG;
      end
      if (cdb_valid && ent_q[i].valid && ent_q[i].qk != NO_TAG && ent_q[i].qk == cdb_tag) begin
        woken[i].vk = cdb_data;
        woken[i].qk = NO_TAG;
      end
    end

    // Collapse above the dispatched slot, then drop the new entry at the tail.
    for (int i = 0; i < RS_DEPTH; i++) begin
      ent_d[i] = woken[i];
      if (do_disp && i >= int'(sel_idx)) begin
        ent_d[i] = woken[(i == RS_DEPTH - 1) ? i : i + 1];
        if (i == RS_DEPTH - 1) ent_d[i].valid = 1'b0;
      end
      if (do_issue && wr_idx == CW'(i)) ent_d[i] = new_ent;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count_q <= '0;
      for (int i = 0; i < RS_DEPTH; i++) ent_q[i] <= '0;
    end else begin
      count_q <= count_d;
      for (int i = 0; i < RS_DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

endmodule

// File: tb/tb_rs_station.sv
// Drives an out-of-order and an in-order station with the same directed stimulus
// and checks both against a queue-based model every cycle plus literal spot checks.
module tb_rs_station;
  import rs_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst, flush, issue_valid, disp_ready, cdb_valid;
  logic [6:0] issue_opcode, issue_fun7;
  logic [2:0] issue_fun3;
  logic [4:0] issue_dtag, issue_qj, issue_qk, cdb_tag;
  logic [31:0] issue_vj, issue_vk, issue_imm, cdb_data;

  logic [1:0] dv, ir, fl, em;
  logic [1:0][2:0] cnt;
  logic [1:0][6:0] d_op, d_f7;
  logic [1:0][2:0] d_f3;
  logic [1:0][4:0] d_dtag;
  logic [1:0][31:0] d_vj, d_vk, d_imm;

  int total = 0;
  int bad = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    rs_station #(.RS_DEPTH(DEPTH), .XLEN(32), .TAG_W(5), .IN_ORDER(gi == 1)) u_dut (
      .clk(clk), .rst(rst), .flush(flush),
      .issue_valid(issue_valid), .issue_ready(ir[gi]),
      .issue_opcode(issue_opcode), .issue_fun3(issue_fun3), .issue_fun7(issue_fun7),
      .issue_dtag(issue_dtag), .issue_vj(issue_vj), .issue_qj(issue_qj),
      .issue_vk(issue_vk), .issue_qk(issue_qk), .issue_imm(issue_imm),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .disp_valid(dv[gi]), .disp_ready(disp_ready),
      .disp_opcode(d_op[gi]), .disp_fun3(d_f3[gi]), .disp_fun7(d_f7[gi]),
      .disp_dtag(d_dtag[gi]), .disp_vj(d_vj[gi]), .disp_vk(d_vk[gi]), .disp_imm(d_imm[gi]),
      .count(cnt[gi]), .full(fl[gi]), .empty(em[gi])
    );
  end

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  dtag;
    logic [31:0] vj;
    logic [4:0]  qj;
    logic [31:0] vk;
    logic [4:0]  qk;
    logic [31:0] imm;
  } m_ent_t;

  m_ent_t mq0[$];
  m_ent_t mq1[$];

  task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s inst=%0d got=%h want=%h t=%0t", nm, k, got, want, $time);
    end
  endtask

  // Oldest ready op wins; an in-order station gives up after the head.
  function automatic int m_sel(input m_ent_t q[$], input bit ino);
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].qj == 5'd0 && q[i].qk == 5'd0) return i;
      if (ino) return -1;
    end
    return -1;
  endfunction

  task automatic m_step(input m_ent_t qi[$], input bit ino, output m_ent_t qo[$]);
    int s;
    bit acc;
    m_ent_t e;
    qo = qi;
    if (rst || flush) begin
      qo.delete();
      return;
    end
    s = m_sel(qi, ino);
    acc = issue_valid && (qi.size() < DEPTH);
    for (int i = 0; i < qo.size(); i++) begin
      if (cdb_valid && cdb_tag != 5'd0 && qo[i].qj == cdb_tag) begin qo[i].vj = cdb_data; qo[i].qj = 5'd0; end
      if (cdb_valid && cdb_tag != 5'd0 && qo[i].qk == cdb_tag) begin qo[i].vk = cdb_data; qo[i].qk = 5'd0; end
    end
    if (s >= 0 && disp_ready) qo.delete(s);
    if (acc) begin
      e = '{op: issue_opcode, f3: issue_fun3, f7: issue_fun7, dtag: issue_dtag, vj: issue_vj,
            qj: issue_qj, vk: issue_vk, qk: issue_qk, imm: issue_imm};
      if (cdb_valid && cdb_tag != 5'd0 && e.qj == cdb_tag) begin e.vj = cdb_data; e.qj = 5'd0; end
      if (cdb_valid && cdb_tag != 5'd0 && e.qk == cdb_tag) begin e.vk = cdb_data; e.qk = 5'd0; end
      qo.push_back(e);
    end
  endtask

  always @(posedge clk) begin
    m_ent_t t0[$];
    m_ent_t t1[$];
    m_step(mq0, 1'b0, t0);
    m_step(mq1, 1'b1, t1);
    mq0 = t0;
    mq1 = t1;
    started = 1'b1;
  end

  task automatic check_inst(input int k, input m_ent_t q[$]);
    int s;
    s = m_sel(q, k == 1);
    chk("count", k, 32'(cnt[k]), 32'(q.size()));
    chk("empty", k, 32'(em[k]), 32'(q.size() == 0));
    chk("full", k, 32'(fl[k]), 32'(q.size() == DEPTH));
    chk("issue_ready", k, 32'(ir[k]), 32'((q.size() < DEPTH) && !flush && !rst));
    chk("disp_valid", k, 32'(dv[k]), 32'(s >= 0));
    if (s >= 0) begin
      chk("disp_dtag", k, 32'(d_dtag[k]), 32'(q[s].dtag));
      chk("disp_opcode", k, 32'(d_op[k]), 32'(q[s].op));
      chk("disp_fun3", k, 32'(d_f3[k]), 32'(q[s].f3));
      chk("disp_fun7", k, 32'(d_f7[k]), 32'(q[s].f7));
      chk("disp_vj", k, d_vj[k], q[s].vj);
      chk("disp_vk", k, d_vk[k], q[s].vk);
      chk("disp_imm", k, d_imm[k], q[s].imm);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      check_inst(0, mq0);
      check_inst(1, mq1);
    end
  end

  // Inputs change 1 time unit after the edge and are settled well before the negedge.
  task automatic tick();
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    cdb_valid = 1'b0;
    flush = 1'b0;
    #2;
  endtask

  task automatic issue(input logic [4:0] dtag, input logic [4:0] qj, input logic [31:0] vj,
                       input logic [4:0] qk, input logic [31:0] vk);
    issue_valid = 1'b1;
    issue_opcode = OP_IMM;
    issue_fun3 = dtag[2:0];
    issue_fun7 = {2'b00, dtag};
    issue_dtag = dtag;
    issue_qj = qj;
    issue_vj = vj;
    issue_qk = qk;
    issue_vk = vk;
    issue_imm = 32'd100 + 32'(dtag);
  endtask

  task automatic bcast(input logic [4:0] tag, input logic [31:0] data);
    cdb_valid = 1'b1;
    cdb_tag = tag;
    cdb_data = data;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; disp_ready = 1'b0;
    issue_valid = 1'b0; issue_opcode = '0; issue_fun3 = '0; issue_fun7 = '0; issue_dtag = '0;
    issue_vj = '0; issue_qj = '0; issue_vk = '0; issue_qk = '0; issue_imm = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
    tick(); tick();
    chk("rst_count", 0, 32'(cnt[0]), 32'd0);
    chk("rst_empty", 0, 32'(em[0]), 32'd1);
    chk("rst_full", 0, 32'(fl[0]), 32'd0);
    chk("rst_issue_ready", 0, 32'(ir[0]), 32'd0);
    chk("rst_disp_valid", 0, 32'(dv[0]), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_issue_ready", 0, 32'(ir[0]), 32'd1);

    // Ready-at-issue op dispatches one edge after issue.
    disp_ready = 1'b1;
    issue(5'd3, 5'd0, 32'd5, 5'd0, 32'd7);
    tick();
    chk("t1_dv", 0, 32'(dv[0]), 32'd1);
    chk("t1_vj", 0, d_vj[0], 32'd5);
    chk("t1_vk", 0, d_vk[0], 32'd7);
    chk("t1_dtag", 0, 32'(d_dtag[0]), 32'd3);
    tick();
    chk("t1_count", 0, 32'(cnt[0]), 32'd0);

    // Wakeup from the CDB two cycles after issue.
    issue(5'd1, 5'd4, 32'd0, 5'd0, 32'd9);
    tick(); tick();
    chk("t2_wait_dv", 0, 32'(dv[0]), 32'd0);
    bcast(5'd4, 32'hDEAD);
    tick();
    chk("t2_dv", 0, 32'(dv[0]), 32'd1);
    chk("t2_vj", 0, d_vj[0], 32'hDEAD);
    tick();
    chk("t2_count", 0, 32'(cnt[0]), 32'd0);

    // Issue-cycle bypass.
    issue(5'd2, 5'd6, 32'd0, 5'd0, 32'd3);
    bcast(5'd6, 32'h11);
    tick();
    chk("t3_dv", 0, 32'(dv[0]), 32'd1);
    chk("t3_vj", 0, d_vj[0], 32'h11);
    tick();
    chk("t3_count", 0, 32'(cnt[0]), 32'd0);

    // Fill, refuse issue while full, then wake slot 2 and collapse.
    disp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue(5'(20 + i), 5'(10 + i), 32'd0, 5'd0, 32'(i));
      tick();
    end
    chk("t4_full", 0, 32'(fl[0]), 32'd1);
    chk("t4_issue_ready", 0, 32'(ir[0]), 32'd0);
    issue(5'd30, 5'd0, 32'd1, 5'd0, 32'd1);
    tick();
    chk("t4_count_full", 0, 32'(cnt[0]), 32'd4);
    bcast(5'd12, 32'h1234);
    disp_ready = 1'b1;
    tick();
    chk("t4_dv", 0, 32'(dv[0]), 32'd1);
    chk("t4_dtag", 0, 32'(d_dtag[0]), 32'd22);
    chk("t4_vj", 0, d_vj[0], 32'h1234);
    chk("t4_ino_dv", 1, 32'(dv[1]), 32'd0);
    tick();
    chk("t4_count", 0, 32'(cnt[0]), 32'd3);
    chk("t4_ino_count", 1, 32'(cnt[1]), 32'd4);
    bcast(5'd10, 32'hA); tick();
    bcast(5'd11, 32'hB); tick();
    bcast(5'd13, 32'hD); tick();
    tick(); tick(); tick(); tick();
    chk("t4_drain0", 0, 32'(cnt[0]), 32'd0);
    chk("t4_drain1", 1, 32'(cnt[1]), 32'd0);

    // In-order head blocks a younger ready op.
    issue(5'd5, 5'd9, 32'd0, 5'd0, 32'd0);
    tick();
    issue(5'd6, 5'd0, 32'h66, 5'd0, 32'd0);
    tick();
    chk("t5_ino_blocked", 1, 32'(dv[1]), 32'd0);
    chk("t5_ooo_dtag", 0, 32'(d_dtag[0]), 32'd6);
    tick();
    chk("t5_ino_blocked2", 1, 32'(dv[1]), 32'd0);
    chk("t5_ino_count", 1, 32'(cnt[1]), 32'd2);
    bcast(5'd9, 32'h99);
    tick();
    chk("t5_head_dv", 1, 32'(dv[1]), 32'd1);
    chk("t5_head_dtag", 1, 32'(d_dtag[1]), 32'd5);
    chk("t5_head_vj", 1, d_vj[1], 32'h99);
    tick();
    chk("t5_next_dtag", 1, 32'(d_dtag[1]), 32'd6);
    tick();
    chk("t5_count", 1, 32'(cnt[1]), 32'd0);

    // Flush with a concurrent issue and broadcast.
    disp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      issue(5'(24 + i), 5'd14, 32'd0, 5'd0, 32'd0);
      tick();
    end
    chk("t6_count3", 0, 32'(cnt[0]), 32'd3);
    flush = 1'b1;
    issue(5'd27, 5'd0, 32'd1, 5'd0, 32'd1);
    bcast(5'd14, 32'h77);
    tick();
    chk("t6_count", 0, 32'(cnt[0]), 32'd0);
    chk("t6_empty", 0, 32'(em[0]), 32'd1);
    chk("t6_dv", 0, 32'(dv[0]), 32'd0);
    issue(5'd28, 5'd14, 32'd0, 5'd0, 32'd0);
    tick();
    chk("t6_after_dv", 0, 32'(dv[0]), 32'd0);
    bcast(5'd14, 32'h55);
    disp_ready = 1'b1;
    tick();
    chk("t6_wake_vj", 0, d_vj[0], 32'h55);
    tick();
    chk("t6_final", 0, 32'(cnt[0]), 32'd0);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rs_station.md
Name: rs_station

Overview:
- Parametrised Tomasulo reservation station; one instance per functional unit (ALU, branch, load/store).
- Holds issued micro-ops until both operands are ready, snoops the common data bus (CDB) for producer tags, and dispatches the oldest ready entry to its unit.
- Adds entries to the older single-unit station, plus a valid/ready handshake, flush, and an in-order mode for memory ops.

Parameters:
- RS_DEPTH, 4, number of entries (2..16).
- XLEN, 32, operand/immediate width.
- TAG_W, 5, producer tag width; tag 0 means "value present, no dependency".
- IN_ORDER, 0, 1 = only the oldest entry may dispatch (load/store station).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  synchronous squash of all entries (mispredict).
- issue_valid  in  1  issue request.
- issue_ready  out  1  entry available; issue_ready = !full && !flush && !rst.
- issue_opcode  in  7  opcode.
- issue_fun3  in  3  funct3.
- issue_fun7  in  7  funct7.
- issue_dtag  in  TAG_W  destination tag of this op.
- issue_vj  in  XLEN  rs1 value.
- issue_qj  in  TAG_W  rs1 producer tag.
- issue_vk  in  XLEN  rs2 value.
- issue_qk  in  TAG_W  rs2 producer tag.
- issue_imm  in  XLEN  immediate.
- cdb_valid  in  1  broadcast valid.
- cdb_tag  in  TAG_W  broadcast tag.
- cdb_data  in  XLEN  broadcast value.
- disp_valid  out  1  a selected entry is ready.
- disp_ready  in  1  unit accepts.
- disp_opcode, disp_fun3, disp_fun7, disp_dtag, disp_vj, disp_vk, disp_imm  out  as issue  fields of the selected entry.
- count  out  $clog2(RS_DEPTH+1)  occupied entries.
- full  out  1  count == RS_DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Storage: collapsing age-ordered queue; slot 0 holds the oldest entry, and valid slots are always 0..count-1.
- Issue (issue_valid && issue_ready): the entry is written at slot count, or at count-1 if a dispatch also occurs that cycle.
- Issue-cycle bypass: if cdb_valid and qj != 0 and qj == cdb_tag, the entry stores vj = cdb_data, qj = 0. The same rule applies to qk.
- Wakeup: every valid entry with qj == cdb_tag (qj != 0) captures vj = cdb_data and clears qj; the same rule applies to qk. Both operands may wake in the same cycle.
- Ready: valid && qj == 0 && qk == 0.
- Select (combinational from registered state):
  - IN_ORDER=0: lowest-index ready slot.
  - IN_ORDER=1: slot 0 only, and only if it is ready.
  - disp_* are driven from the selected slot. disp_valid = a slot is selected. disp_* are don't-care when disp_valid = 0.
- Dispatch (disp_valid && disp_ready): the selected slot is removed at the clock edge and slots above it shift down by one, keeping their wakeup updates from the same edge.
- Latency:
  - Op issued with tags 0 at edge t: disp_valid high after edge t, earliest dispatch at edge t+1.
  - Op woken by the CDB at edge t: dispatchable at edge t+1.
  - No combinational path from cdb_* to disp_valid.
- Full: issue_ready = 0. Issue and dispatch in the same cycle while full are not permitted; issue_ready stays 0 until count drops.
- Stall: if disp_ready = 0, the entry holds and the outputs stay stable. Wakeup of other entries continues.
- rst or flush: all valid bits are cleared and count = 0. Any issue or dispatch in that cycle is discarded and the CDB is ignored.
- Reset values: disp_valid = 0, count = 0, empty = 1, full = 0, issue_ready = 0 during rst and 1 the cycle after.
- Tag 0 on the CDB is never matched.

Decomposition:
- Package rs_pkg holds:
  - opcode/funct constants currently in opcode.h: OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, ALU_ADDSUB, OP_BEQ..OP_BGEU.
  - rs_entry_t struct: valid, opcode, fun3, fun7, dtag, vj, qj, vk, qk, imm.
  - NO_TAG = 0.
- One sub-module, rs_select: parametrised lowest-index priority picker over a ready vector, returning index and found.

Test Plan:
- Issue op with qj=qk=0, vj=5, vk=7, dtag=3, disp_ready=1 -> disp_valid after one edge with vj=5, vk=7, dtag=3; count returns to 0 the next edge.
- Issue qj=4, qk=0; two cycles later cdb_valid, tag=4, data=0xDEAD -> disp_valid the cycle after the broadcast with vj=0xDEAD.
- Issue with qj=6 while cdb_tag=6, data=0x11 in the same cycle -> entry stored ready, vj=0x11, dispatched next cycle.
- RS_DEPTH=4: issue 4 dependent ops, disp_ready=0 -> full=1, issue_ready=0. Wake slot 2, disp_ready=1 (IN_ORDER=0) -> slot 2 dispatches, slots 3 then 2 shift, count=3.
- IN_ORDER=1: slot 0 waiting on tag 9 and slot 1 ready -> disp_valid=0 until tag 9 broadcast, then slot 0 dispatches, then slot 1.
- Three entries plus flush asserted with issue_valid=1 -> count=0, empty=1, no dispatch; a CDB broadcast in that cycle has no effect.
